// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths, FIFO depth, APB register offsets and the data word type.
package i2c_pkg;
  localparam int I2C_DWIDTH     = 32;
  localparam int I2C_FIFO_DEPTH = 16;
  localparam logic [7:0] I2C_ADDR_TX  = 8'd0;
  localparam logic [7:0] I2C_ADDR_RX  = 8'd4;
  localparam logic [7:0] I2C_ADDR_CFG = 8'd8;
  localparam logic [7:0] I2C_ADDR_TMO = 8'd12;
  typedef logic [I2C_DWIDTH-1:0] i2c_word_t;
endpackage

// File: rtl/i2c_fifo_mem.sv
// i2c_fifo_mem: DEPTH x DWIDTH register array, one synchronous write port, one asynchronous read port.
module i2c_fifo_mem
  import i2c_pkg::*;
#(
  parameter int DWIDTH = I2C_DWIDTH,
  parameter int DEPTH  = I2C_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DWIDTH-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DWIDTH-1:0]        rdata_o
);
  logic [DWIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/i2c_fifo.sv
// i2c_fifo: first-word-fall-through FIFO between the APB front end and the I2C core.
// Occupancy lives in a count register; every flag decodes from it, so all are glitch-free.
module i2c_fifo
  import i2c_pkg::*;
#(
  parameter int DWIDTH   = I2C_DWIDTH,
  parameter int DEPTH    = I2C_FIFO_DEPTH,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   wr_en,
  input  logic [DWIDTH-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DWIDTH-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_err
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic ovf_q, ovf_d, unf_q, unf_d, wr_ok, rd_ok;
  // A pop on a full FIFO frees its slot in the same edge, so the push is still taken.
  always_comb begin
    rd_ok    = rd_en & ~empty;
    wr_ok    = wr_en & (~full | rd_ok);
    wr_ptr_d = wr_ok ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    count_d  = (wr_ok & ~rd_ok) ? count_q + cnt_t'(1) :
               (rd_ok & ~wr_ok) ? count_q - cnt_t'(1) : count_q;
    ovf_d    = (ovf_q & ~clr_err) | (wr_en & ~wr_ok);
    unf_d    = (unf_q & ~clr_err) | (rd_en & empty);
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  assign full         = count_q == cnt_t'(DEPTH);
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= cnt_t'(AF_LEVEL);
  assign almost_empty = count_q <= cnt_t'(AE_LEVEL);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  i2c_fifo_mem #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_mem (
    .clk    (PCLK),
    .we_i   (wr_ok),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );
endmodule

// File: tb/tb_i2c_fifo.sv
// tb_i2c_fifo: directed and random push/pop traffic checked against a queue-based model.
module tb_i2c_fifo;
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  count;
  int          n_asrt = 0, n_fail = 0;
  logic [31:0] q[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0;
  i2c_fifo dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );
  always #5 PCLK = ~PCLK;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    int sz = q.size();
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == 16));
    chk("almost_full", 32'(almost_full), 32'(sz >= 12));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (sz > 0) chk("rd_data", rd_data, q[0]);
  endtask
  task automatic step(input logic w, input logic [31:0] d, input logic r, input logic c);
    int  sz = q.size();
    bit  rok = r && sz > 0;
    bit  wok = w && (sz < 16 || rok);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    @(posedge PCLK);
    if (rok) void'(q.pop_front());
    if (wok) q.push_back(d);
    m_ovf = (m_ovf & ~c) | (w & ~wok);
    m_unf = (m_unf & ~c) | (r & (sz == 0));
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    check_all();
  endtask
  task automatic do_reset();
    PRESETn = 1'b0;
    @(posedge PCLK);
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    PRESETn = 1'b1;
    check_all();
  endtask
  initial begin
    do_reset();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ae", 32'(almost_empty), 32'd1);
    for (int i = 0; i < 16; i++) step(1, 32'h1000 + i, 0, 0);
    chk("t1_full", 32'(full), 32'd1);
    chk("t1_count", 32'(count), 32'd16);
    step(1, 32'hDEAD_0000, 0, 0);
    chk("t1_overflow", 32'(overflow), 32'd1);
    chk("t1_head_kept", rd_data, 32'h1000);
    step(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", rd_data, 32'h1000 + i);
      step(0, 0, 1, 0);
    end
    chk("t2_empty", 32'(empty), 32'd1);
    step(0, 0, 1, 0);
    chk("t2_underflow", 32'(underflow), 32'd1);
    step(0, 0, 0, 1);
    step(1, 32'hA5A5_A5A5, 0, 0);
    chk("t3_empty", 32'(empty), 32'd0);
    chk("t3_data", rd_data, 32'hA5A5_A5A5);
    step(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, $urandom, 0, 0);
    step(1, 32'h0000_BEEF, 1, 0);
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t4_last", rd_data, 32'h0000_BEEF);
      step(0, 0, 1, 0);
    end
    step(1, 32'h1234_5678, 1, 0);
    chk("t5_underflow", 32'(underflow), 32'd1);
    chk("t5_count", 32'(count), 32'd1);
    chk("t5_data", rd_data, 32'h1234_5678);
    step(0, 0, 0, 1);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 50, 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 9) == 0);
    while (q.size() > 0) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
    chk("t6_pre_count", 32'(count), 32'd5);
    do_reset();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_sticky", {30'd0, overflow, underflow}, 32'd0);
    for (int i = 0; i < 16; i++) step(1, $urandom, 0, 0);
    step(1, 32'hFACE, 0, 1);
    chk("t6_ovf_wins", 32'(overflow), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
